// File: rtl/fifo_pkg.sv
// fifo_pkg: shared sizing helpers and status bit map
// for the synchronous FIFO controller slice.
package fifo_pkg;

    localparam int FIFO_WIDTH = 8;
    localparam int FIFO_DEPTH = 16;

    // Bit positions of the sticky error flags in the status map
    localparam int ERR_OVERFLOW  = 0;
    localparam int ERR_UNDERFLOW = 1;

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: wrap-bit pointer, AW address bits plus one
// lap bit that toggles each time the address wraps to 0.
module fifo_ptr #(
    parameter int AW = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [AW:0] ptr
);

    localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + ONE;
        end
    end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: push/pop front end for a registered-read
// dual-port RAM with occupancy, level and sticky error status.
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int Width         = FIFO_WIDTH,
    parameter int Depth         = FIFO_DEPTH,
    parameter int AlmostFullLvl = 12,
    localparam int AW           = addr_w(Depth)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [Width-1:0] pushData,
    output logic             pushReady,
    input  logic             pop,
    output logic             popValid,
    output logic [Width-1:0] popData,
    output logic             wrEn,
    output logic [AW-1:0]    wrAddr,
    output logic [Width-1:0] wrData,
    output logic [AW-1:0]    rdAddr,
    input  logic [Width-1:0] rdData,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty,
    output logic             almostFull,
    output logic             overflow,
    output logic             underflow,
    input  logic             clrErr
);

    localparam logic [AW:0] ONE    = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] AF_LVL = (AW+1)'(AlmostFullLvl);

    logic [AW:0] wrPtr;
    logic [AW:0] rdPtr;
    logic [AW:0] cnt;
    logic        pushAcc;
    logic        popAcc;
    logic        pvQ;
    logic [1:0]  errEv;
    logic [1:0]  errQ;

    // Same address with different lap bits means a full lap ahead
    assign full  = (wrPtr[AW-1:0] == rdPtr[AW-1:0])
                && (wrPtr[AW] != rdPtr[AW]);
    assign empty = (wrPtr == rdPtr);

    assign pushAcc = push & ~full;
    assign popAcc  = pop & ~empty;

    assign pushReady  = ~full;
    assign wrEn       = pushAcc;
    assign wrAddr     = wrPtr[AW-1:0];
    assign wrData     = pushData;
    assign rdAddr     = rdPtr[AW-1:0];
    assign popData    = rdData;
    assign popValid   = pvQ;
    assign count      = cnt;
    assign almostFull = (cnt >= AF_LVL);

    assign errEv[ERR_OVERFLOW]  = push & full;
    assign errEv[ERR_UNDERFLOW] = pop & empty;
    assign overflow  = errQ[ERR_OVERFLOW];
    assign underflow = errQ[ERR_UNDERFLOW];

    fifo_ptr #(.AW(AW)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (pushAcc),
        .ptr (wrPtr)
    );

    fifo_ptr #(.AW(AW)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (popAcc),
        .ptr (rdPtr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            unique case ({pushAcc, popAcc})
                2'b10:   cnt <= cnt + ONE;
                2'b01:   cnt <= cnt - ONE;
                default: cnt <= cnt;
            endcase
        end
    end

    // RAM read data lands one edge after the pop is sampled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pvQ <= 1'b0;
        end else begin
            pvQ <= popAcc;
        end
    end

    // A new error outranks a clear in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            errQ <= '0;
        end else begin
            errQ <= errEv | (errQ & {2{~clrErr}});
        end
    end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb_sync_fifo_ctrl: FIFO controller with a registered-read RAM,
// checked against a queue-based reference model.
module tb_sync_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic       clrErr = 1'b0;
    logic [7:0] pushData = '0;
    logic [7:0] popData;
    logic [7:0] wrData;
    logic [7:0] rdData;
    logic [3:0] wrAddr;
    logic [3:0] rdAddr;
    logic [4:0] count;
    logic       pushReady;
    logic       popValid;
    logic       wrEn;
    logic       full;
    logic       empty;
    logic       almostFull;
    logic       overflow;
    logic       underflow;

    int checks = 0;
    int fails  = 0;

    logic [7:0] mq[$];
    logic       ovfM = 1'b0;
    logic       udfM = 1'b0;
    logic       expValid = 1'b0;
    logic [7:0] expData = '0;
    logic [7:0] mem [16];

    sync_fifo_ctrl #(
        .Width(8),
        .Depth(16),
        .AlmostFullLvl(12)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pushData   (pushData),
        .pushReady  (pushReady),
        .pop        (pop),
        .popValid   (popValid),
        .popData    (popData),
        .wrEn       (wrEn),
        .wrAddr     (wrAddr),
        .wrData     (wrData),
        .rdAddr     (rdAddr),
        .rdData     (rdData),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .almostFull (almostFull),
        .overflow   (overflow),
        .underflow  (underflow),
        .clrErr     (clrErr)
    );

    // 16x8 dual-port RAM, registered read
    always @(posedge clk) begin
        if (wrEn) mem[wrAddr] <= wrData;
        rdData <= mem[rdAddr];
    end

    always #5 clk = ~clk;

    task automatic model_reset();
        mq.delete();
        ovfM = 1'b0;
        udfM = 1'b0;
        expValid = 1'b0;
    endtask

    // One clock: drive, advance model on pre-edge occupancy, sample at +1
    task automatic cyc(input logic p, input logic [7:0] d,
                       input logic q, input logic c);
        logic pa;
        logic qa;
        push = p;
        pushData = d;
        pop = q;
        clrErr = c;
        pa = p && (mq.size() < 16);
        qa = q && (mq.size() > 0);
        ovfM = (p && !pa) || (ovfM && !c);
        udfM = (q && !qa) || (udfM && !c);
        if (qa) expData = mq.pop_front();
        if (pa) mq.push_back(d);
        expValid = qa;
        @(posedge clk);
        #1;
        push = 1'b0;
        pop = 1'b0;
        clrErr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        checks += 9;
        if (empty !== 1'b1) begin fails++;
            $display("FAIL rst_empty got %b want 1", empty); end
        if (full !== 1'b0) begin fails++;
            $display("FAIL rst_full got %b want 0", full); end
        if (count !== 5'd0) begin fails++;
            $display("FAIL rst_count got %0d want 0", count); end
        if (pushReady !== 1'b1) begin fails++;
            $display("FAIL rst_ready got %b want 1", pushReady); end
        if (popValid !== 1'b0) begin fails++;
            $display("FAIL rst_pv got %b want 0", popValid); end
        if (wrEn !== 1'b0) begin fails++;
            $display("FAIL rst_wren got %b want 0", wrEn); end
        if (almostFull !== 1'b0) begin fails++;
            $display("FAIL rst_af got %b want 0", almostFull); end
        if (overflow !== 1'b0) begin fails++;
            $display("FAIL rst_ovf got %b want 0", overflow); end
        if (underflow !== 1'b0) begin fails++;
            $display("FAIL rst_udf got %b want 0", underflow); end
    endtask

    task automatic test_basic();
        logic [7:0] want [3];
        want[0] = 8'h11;
        want[1] = 8'h22;
        want[2] = 8'h33;
        for (int i = 0; i < 3; i++) cyc(1'b1, want[i], 1'b0, 1'b0);
        checks++;
        if (count !== 5'd3) begin fails++;
            $display("FAIL basic_cnt got %0d want 3", count); end
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            checks += 2;
            if (popValid !== 1'b1) begin fails++;
                $display("FAIL basic_pv[%0d] got %b want 1", i, popValid); end
            if (popData !== want[i]) begin fails++;
                $display("FAIL basic_data[%0d] got %h want %h",
                         i, popData, want[i]); end
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        checks += 3;
        if (popValid !== 1'b0) begin fails++;
            $display("FAIL basic_pv_end got %b want 0", popValid); end
        if (count !== 5'd0) begin fails++;
            $display("FAIL basic_cnt_end got %0d want 0", count); end
        if (empty !== 1'b1) begin fails++;
            $display("FAIL basic_empty got %b want 1", empty); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 8'(i), 1'b0, 1'b0);
            checks += 4;
            if (count !== 5'(i + 1)) begin fails++;
                $display("FAIL fill_cnt got %0d want %0d", count, i + 1); end
            if (almostFull !== (i + 1 >= 12)) begin fails++;
                $display("FAIL fill_af at %0d got %b", i + 1, almostFull); end
            if (full !== (i + 1 == 16)) begin fails++;
                $display("FAIL fill_full at %0d got %b", i + 1, full); end
            if (pushReady !== (i + 1 < 16)) begin fails++;
                $display("FAIL fill_ready at %0d got %b", i + 1, pushReady); end
        end
        cyc(1'b1, 8'hAA, 1'b1, 1'b0);
        checks += 5;
        if (popValid !== 1'b1) begin fails++;
            $display("FAIL full_pv got %b want 1", popValid); end
        if (popData !== 8'h00) begin fails++;
            $display("FAIL full_data got %h want 00", popData); end
        if (count !== 5'd15) begin fails++;
            $display("FAIL full_cnt got %0d want 15", count); end
        if (overflow !== 1'b1) begin fails++;
            $display("FAIL full_ovf got %b want 1", overflow); end
        if (full !== 1'b0) begin fails++;
            $display("FAIL full_flag got %b want 0", full); end
        for (int i = 1; i < 16; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            checks += 2;
            if (popValid !== 1'b1) begin fails++;
                $display("FAIL drain_pv[%0d] got %b want 1", i, popValid); end
            if (popData !== 8'(i)) begin fails++;
                $display("FAIL drain_data got %h want %h", popData, 8'(i)); end
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        checks += 3;
        if (popValid !== 1'b0) begin fails++;
            $display("FAIL drain_pv_end got %b want 0", popValid); end
        if (empty !== 1'b1) begin fails++;
            $display("FAIL drain_empty got %b want 1", empty); end
        if (overflow !== 1'b0) begin fails++;
            $display("FAIL clr_ovf got %b want 0", overflow); end
    endtask

    task automatic test_wrap();
        int sent = 0;
        int got = 0;
        int sz;
        logic p;
        logic q;
        for (int n = 0; n < 400 && (sent < 40 || mq.size() > 0); n++) begin
            sz = mq.size();
            p = (sent < 40) && (sz < 5)
             && (sz < 3 || $urandom_range(0, 1) == 1);
            q = (sz > 0)
             && (sent == 40 || (sz >= 3 && $urandom_range(0, 1) == 1));
            if (p) sent++;
            cyc(p, 8'($urandom_range(0, 255)), q, 1'b0);
            checks += 2;
            if (popValid !== expValid) begin fails++;
                $display("FAIL wrap_pv got %b want %b", popValid, expValid); end
            if (count !== 5'(mq.size()) || count > 5'd5) begin fails++;
                $display("FAIL wrap_cnt got %0d want %0d",
                         count, mq.size()); end
            if (expValid) begin
                got++;
                checks++;
                if (popData !== expData) begin fails++;
                    $display("FAIL wrap_data got %h want %h",
                             popData, expData); end
            end
        end
        checks += 2;
        if (got != 40) begin fails++;
            $display("FAIL wrap_total got %0d want 40", got); end
        if (overflow !== 1'b0 || underflow !== 1'b0) begin fails++;
            $display("FAIL wrap_err got %b%b want 00", overflow, underflow); end
    endtask

    task automatic test_random();
        logic p;
        logic q;
        for (int n = 0; n < 300; n++) begin
            if (n < 150) p = ($urandom_range(0, 9) < 7);
            else p = ($urandom_range(0, 9) < 3);
            q = ($urandom_range(0, 9) < 4 + n / 60);
            cyc(p, 8'($urandom_range(0, 255)), q,
                $urandom_range(0, 15) == 0);
            checks += 7;
            if (count !== 5'(mq.size())) begin fails++;
                $display("FAIL rnd_cnt got %0d want %0d", count, mq.size()); end
            if (full !== (mq.size() == 16)) begin fails++;
                $display("FAIL rnd_full got %b", full); end
            if (empty !== (mq.size() == 0)) begin fails++;
                $display("FAIL rnd_empty got %b", empty); end
            if (almostFull !== (mq.size() >= 12)) begin fails++;
                $display("FAIL rnd_af got %b", almostFull); end
            if (popValid !== expValid) begin fails++;
                $display("FAIL rnd_pv got %b want %b", popValid, expValid); end
            if (overflow !== ovfM) begin fails++;
                $display("FAIL rnd_ovf got %b want %b", overflow, ovfM); end
            if (underflow !== udfM) begin fails++;
                $display("FAIL rnd_udf got %b want %b", underflow, udfM); end
            if (expValid) begin
                checks++;
                if (popData !== expData) begin fails++;
                    $display("FAIL rnd_data got %h want %h",
                             popData, expData); end
            end
        end
    endtask

    task automatic test_underflow();
        for (int n = 0; n < 40 && mq.size() > 0; n++)
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        checks += 2;
        if (empty !== 1'b1) begin fails++;
            $display("FAIL udf_pre_empty got %b want 1", empty); end
        if (underflow !== 1'b0) begin fails++;
            $display("FAIL udf_pre got %b want 0", underflow); end
        cyc(1'b1, 8'h5C, 1'b1, 1'b0);
        checks += 3;
        if (underflow !== 1'b1) begin fails++;
            $display("FAIL udf_set got %b want 1", underflow); end
        if (popValid !== 1'b0) begin fails++;
            $display("FAIL udf_pv got %b want 0", popValid); end
        if (count !== 5'd1) begin fails++;
            $display("FAIL udf_cnt got %0d want 1", count); end
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        checks += 2;
        if (popValid !== 1'b1) begin fails++;
            $display("FAIL udf_pv2 got %b want 1", popValid); end
        if (popData !== 8'h5C) begin fails++;
            $display("FAIL udf_data got %h want 5c", popData); end
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        checks++;
        if (underflow !== 1'b0) begin fails++;
            $display("FAIL udf_clr got %b want 0", underflow); end
    endtask

    task automatic test_rst_mid();
        cyc(1'b1, 8'h77, 1'b0, 1'b0);
        cyc(1'b1, 8'h78, 1'b1, 1'b0);
        checks++;
        if (popValid !== 1'b1) begin fails++;
            $display("FAIL rmid_pv_pre got %b want 1", popValid); end
        #2;
        rst = 1'b1;
        #1;
        checks += 3;
        if (popValid !== 1'b0) begin fails++;
            $display("FAIL rmid_pv got %b want 0", popValid); end
        if (count !== 5'd0) begin fails++;
            $display("FAIL rmid_cnt got %0d want 0", count); end
        if (empty !== 1'b1) begin fails++;
            $display("FAIL rmid_empty got %b want 1", empty); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        checks += 3;
        if (popValid !== 1'b0) begin fails++;
            $display("FAIL rmid_pv_post got %b want 0", popValid); end
        if (count !== 5'd0) begin fails++;
            $display("FAIL rmid_cnt_post got %0d want 0", count); end
        if (empty !== 1'b1) begin fails++;
            $display("FAIL rmid_empty_post got %b want 1", empty); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill();
        test_wrap();
        test_random();
        test_underflow();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
- Synchronous FIFO controller directly upstream of the 16x8 dual-port registered-read `ram` block.
- Converts a push/pop stream interface into the RAM's `wrEn`/`wrAddr`/`wrData`/`rdAddr` controls.
- Consumes the RAM's `rdData`, which arrives 1 cycle after the read address is sampled.
- Generates occupancy, flag and error status for the surrounding datapath.

Parameters:
- Width, 8, data word width; must match the RAM `Width`.
- Depth, 16, entry count; must match the RAM `Depth`; power of 2, at least 4.
- AlmostFullLvl, 12, count at or above which `almostFull` asserts; range 1..Depth.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- push  input  1  write request.
- pushData  input  Width  write data.
- pushReady  output  1  push accepted this cycle when high (equals !full).
- pop  input  1  read request.
- popValid  output  1  popData valid this cycle.
- popData  output  Width  read data.
- wrEn  output  1  to RAM wrEn.
- wrAddr  output  $clog2(Depth)  to RAM wrAddr.
- wrData  output  Width  to RAM wrData.
- rdAddr  output  $clog2(Depth)  to RAM rdAddr.
- rdData  input  Width  from RAM rdData.
- count  output  $clog2(Depth)+1  current occupancy, 0..Depth.
- full  output  1  count == Depth.
- empty  output  1  count == 0.
- almostFull  output  1  count >= AlmostFullLvl.
- overflow  output  1  sticky: push while full.
- underflow  output  1  sticky: pop while empty.
- clrErr  input  1  synchronous clear of overflow and underflow.

Behaviour:
- Reset (async assert, sync release):
  - wrPtr=0, rdPtr=0, count=0, popValid=0, overflow=0, underflow=0.
  - Resulting outputs: empty=1, full=0, pushReady=1, almostFull=0.
  - RAM contents are not cleared; the controller never reads stale entries.
- Pointers are $clog2(Depth)+1 bits with an MSB wrap bit.
  - wrAddr = wrPtr[AW-1:0]; rdAddr = rdPtr[AW-1:0] (combinational).
  - Wrap from Depth-1 to 0 toggles the MSB.
  - full when the address bits are equal and the MSBs differ; empty when all bits are equal.
- Push accept: pushAcc = push & !full.
  - wrEn = pushAcc (combinational); wrData = pushData.
  - wrPtr increments on the same edge.
- Push while full is rejected even if pop is also accepted that cycle.
  - This prevents a same-address read/write in one cycle (wrAddr == rdAddr when full).
  - The rejection sets overflow.
- Pop accept: popAcc = pop & !empty.
  - rdAddr is sampled by the RAM at that edge, and rdPtr increments on the same edge.
  - popValid is a registered copy of popAcc: high exactly 1 cycle later, for 1 cycle per accepted pop.
  - popData = rdData, passed through with no extra register.
  - Total pop-to-data latency is 1 cycle.
- Pop while empty is rejected and sets underflow.
  - A push in the same cycle is still accepted.
  - There is no fall-through: the earliest pop after a push into an empty FIFO is the next cycle, with data the cycle after that.
- count update (registered): +1 on pushAcc only; -1 on popAcc only; unchanged when both or neither occur.
- overflow/underflow:
  - Set on the error event; hold until clrErr or rst.
  - If clrErr and a new error occur in the same cycle, the error wins (flag stays 1).
- Read/write address collision is impossible:
  - A pop reads only entries written on earlier edges.
  - Writes target only free slots.
- Reset mid-operation:
  - Asserting rst while popValid is pending forces popValid=0 immediately.
  - No pending data is delivered after release.

Decomposition:
- Shared package fifo_pkg holds:
  - function addr_w(Depth) returning $clog2(Depth);
  - localparam defaults FIFO_WIDTH=8, FIFO_DEPTH=16;
  - the error-flag bit positions {overflow=0, underflow=1} for the status register map.
- One natural sub-module: fifo_ptr.
  - Wrap-bit pointer register with increment enable and async reset.
  - Instantiated twice, for wrPtr and rdPtr.
- Flag and count logic stays in the top.
- Bench pairs sync_fifo_ctrl with the existing `ram` (Width=8, Depth=16).

Test Plan:
- Reset then idle -> empty=1, full=0, count=0, pushReady=1, popValid=0, wrEn=0.
- Push 0x11,0x22,0x33 on consecutive cycles, then pop 3 consecutive cycles -> popValid high on 3 cycles, each 1 cycle after its pop; popData 0x11,0x22,0x33; count back to 0; empty=1.
- Push 16 words 0x00..0x0F -> full=1 and pushReady=0 after the 16th; almostFull asserts at count=12. Then push 0xAA with pop -> pop accepted, push rejected: count=15, overflow=1, popData=0x00. Later pops return 0x01..0x0F with no 0xAA.
- Fill/drain 40 words with push and pop interleaved at count 3..5 -> pointers wrap twice, output order matches input, count never exceeds 5, no errors.
- Pop while empty with a simultaneous push of 0x5C -> underflow=1, no popValid next cycle, count=1. The following pop returns 0x5C. clrErr pulse -> underflow=0.
- Pop accepted, then rst asserted asynchronously before the next edge -> popValid=0 immediately; count=0 and empty=1 after release.
